// File: rtl/ddr_to_cpu_handshake_tx.sv
// Transmit side of the clk_ddr -> CPU return path: single-cycle events are queued in a small
// FIFO and sent one word at a time over a 4-phase req/ack handshake with a synchronized ack.
module ddr_to_cpu_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int FIFO_AW     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_ddr,
    input  logic              rst,
    input  logic              ev_valid,
    input  logic [DATA_W-1:0] ev_data,
    output logic              ev_ready,
    output logic              req_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack_in,
    output logic              busy,
    output logic              overflow,
    output logic              timeout_err,
    input  logic              clr_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACK_LOW = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] ack_meta;
    logic                   ack_sync;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [FIFO_AW:0]  wr_ptr;
    logic [FIFO_AW:0]  rd_ptr;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              phase_stay;
    logic              tmo_set;
    logic              ovf_set;

    // ------------------------------------------------------------------
    // ack_in synchronizer
    // ------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample pre-edge values; blocking here would collapse the sync chain.
    always_ff @(posedge clk_ddr) begin
        if (rst) begin
            ack_meta <= '0;
        end else begin
            ack_meta <= {ack_meta[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_sync = ack_meta[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Event FIFO: extra pointer bit tells full from empty
    // ------------------------------------------------------------------
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign ev_ready = !full;
    assign push     = ev_valid && !full;
    assign ovf_set  = ev_valid && full;

    // NOTE: storage is not reset; the pointers alone define which entries are
    // valid, so resetting the array would only cost reset routing.
    always_ff @(posedge clk_ddr) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= ev_data;
        end
    end

    always_ff @(posedge clk_ddr) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_ddr) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    // NOTE: each always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_sync) begin
                    state_d = ST_ACK_LOW;
                end
            end
            ST_ACK_LOW: begin
                if (!ack_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / control logic
    always_comb begin
        pop        = (state_q == ST_IDLE) && !empty;
        phase_stay = (state_q != ST_IDLE) && (state_d == state_q);
        cnt_d      = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (phase_stay && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Flag on the edge where the phase has lasted TIMEOUT_CYC cycles.
        tmo_set = (TIMEOUT_CYC != 0) && phase_stay && (cnt_q == CNT_LAST);
    end

    // ------------------------------------------------------------------
    // Registered outputs, phase counter and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk_ddr) begin
        if (rst) begin
            req_out     <= 1'b0;
            data_out    <= '0;
            cnt_q       <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            req_out <= (state_d == ST_REQ);
            if (pop) begin
                data_out <= mem[rd_ptr[FIFO_AW-1:0]];
            end
            cnt_q       <= cnt_d;
            // A new error in the clearing cycle wins over clr_err.
            overflow    <= ovf_set || (overflow && !clr_err);
            timeout_err <= tmo_set || (timeout_err && !clr_err);
        end
    end

    assign busy = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr_to_cpu_handshake_tx.sv
// Self-checking bench for ddr_to_cpu_handshake_tx: directed scenarios plus a randomized run
// scored against a transaction-level queue model of accepted-but-unsent words.
module tb_ddr_to_cpu_handshake_tx;

    localparam int DATA_W      = 8;
    localparam int FIFO_AW     = 2;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 16;

    logic              clk_ddr = 1'b0;
    logic              rst;
    logic              ev_valid;
    logic [DATA_W-1:0] ev_data;
    logic              ev_ready;
    logic              req_out;
    logic [DATA_W-1:0] data_out;
    logic              ack_in;
    logic              busy;
    logic              overflow;
    logic              timeout_err;
    logic              clr_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Words accepted by the FIFO but not yet launched, oldest first.
    logic [DATA_W-1:0] pend_q[$];
    logic [DATA_W-1:0] rx_log[$];
    logic              ovf_exp  = 1'b0;
    logic              req_prev = 1'b0;
    logic [DATA_W-1:0] held     = '0;

    ddr_to_cpu_handshake_tx #(
        .DATA_W      (DATA_W),
        .FIFO_AW     (FIFO_AW),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_ddr     (clk_ddr),
        .rst         (rst),
        .ev_valid    (ev_valid),
        .ev_data     (ev_data),
        .ev_ready    (ev_ready),
        .req_out     (req_out),
        .data_out    (data_out),
        .ack_in      (ack_in),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    always #5 clk_ddr = ~clk_ddr;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // One clock edge, then score launches and data stability against the queue model.
    task automatic tick();
        logic [DATA_W-1:0] exp;
        @(posedge clk_ddr);
        #1;
        if (req_out === 1'b1 && req_prev !== 1'b1) begin
            n_checks++;
            if (pend_q.size() == 0) begin
                n_fail++;
                $display("FAIL launch_spurious: data_out=%02h launched with no word pending", data_out);
            end else begin
                exp = pend_q.pop_front();
                if (data_out !== exp) begin
                    n_fail++;
                    $display("FAIL launch_order: data_out=%02h expected %02h", data_out, exp);
                end
            end
            rx_log.push_back(data_out);
            held = data_out;
        end else if (req_out === 1'b1) begin
            n_checks++;
            if (data_out !== held) begin
                n_fail++;
                $display("FAIL data_stable: data_out=%02h changed from %02h while req_out=1", data_out, held);
            end
        end
        req_prev = req_out;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        ev_valid = 1'b0;
        ev_data  = '0;
        clr_err  = 1'b0;
        ack_in   = 1'b0;
        pend_q.delete();
        ovf_exp  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // One cycle of event stimulus with the model's view of acceptance and overflow.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic clr);
        logic acc;
        n_checks++;
        if (ev_ready !== (pend_q.size() < DEPTH)) begin
            n_fail++;
            $display("FAIL ev_ready: ev_ready=%b expected %b (pending %0d)", ev_ready,
                     (pend_q.size() < DEPTH), pend_q.size());
        end
        ev_valid = v;
        ev_data  = d;
        clr_err  = clr;
        acc      = v && (pend_q.size() < DEPTH);
        if (acc) pend_q.push_back(d);
        if (v && !acc) ovf_exp = 1'b1;
        else if (clr)  ovf_exp = 1'b0;
        tick();
        ev_valid = 1'b0;
        clr_err  = 1'b0;
        n_checks++;
        if (overflow !== ovf_exp) begin
            n_fail++;
            $display("FAIL overflow_model: overflow=%b expected %b", overflow, ovf_exp);
        end
    endtask

    task automatic wait_req(input logic level, input string what);
        int n;
        n = 0;
        while (req_out !== level && n < 64) begin
            cycle(1'b0, '0, 1'b0);
            n++;
        end
        n_checks++;
        if (req_out !== level) begin
            n_fail++;
            $display("FAIL %s: req_out=%b expected %b within 64 cycles", what, req_out, level);
        end
    endtask

    task automatic cpu_handshake(input int dly);
        wait_req(1'b1, "hs_req_rise");
        repeat (dly) cycle(1'b0, '0, 1'b0);
        ack_in = 1'b1;
        wait_req(1'b0, "hs_req_fall");
        repeat (dly) cycle(1'b0, '0, 1'b0);
        ack_in = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks += 6;
        if (req_out !== 1'b0)     begin n_fail++; $display("FAIL rst_req: req_out=%b expected 0", req_out); end
        if (data_out !== 8'h00)   begin n_fail++; $display("FAIL rst_data: data_out=%02h expected 00", data_out); end
        if (ev_ready !== 1'b1)    begin n_fail++; $display("FAIL rst_ready: ev_ready=%b expected 1", ev_ready); end
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: busy=%b expected 0", busy); end
        if (overflow !== 1'b0)    begin n_fail++; $display("FAIL rst_ovf: overflow=%b expected 0", overflow); end
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_tmo: timeout_err=%b expected 0", timeout_err); end
    endtask

    task automatic test_single();
        apply_reset();
        cycle(1'b1, 8'hA5, 1'b0);
        n_checks++;
        if (req_out !== 1'b0) begin n_fail++; $display("FAIL lat_early: req_out=%b expected 0 after accept edge", req_out); end
        cycle(1'b0, '0, 1'b0);
        n_checks += 2;
        if (req_out !== 1'b1)   begin n_fail++; $display("FAIL lat_req: req_out=%b expected 1 one edge after accept", req_out); end
        if (data_out !== 8'hA5) begin n_fail++; $display("FAIL lat_data: data_out=%02h expected a5", data_out); end
        repeat (4) cycle(1'b0, '0, 1'b0);
        ack_in = 1'b1;
        repeat (SYNC_STAGES) cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (req_out !== 1'b1) begin n_fail++; $display("FAIL ack_sync_delay: req_out=%b expected 1 before ack synchronized", req_out); end
        cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (req_out !== 1'b0) begin n_fail++; $display("FAIL req_fall: req_out=%b expected 0", req_out); end
        ack_in = 1'b0;
        repeat (SYNC_STAGES) cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_ack_low: busy=%b expected 1", busy); end
        cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_end: busy=%b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        rx_log.delete();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0);
        n_checks += 2;
        if (ev_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready4: ev_ready=%b expected 1", ev_ready); end
        if (data_out !== 8'h01) begin n_fail++; $display("FAIL b2b_head: data_out=%02h expected 01", data_out); end
        cycle(1'b1, 8'h05, 1'b0);
        n_checks++;
        if (ev_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: ev_ready=%b expected 0", ev_ready); end
        repeat (5) cpu_handshake(2);
        repeat (4) cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (rx_log.size() != 5) begin
            n_fail++;
            $display("FAIL b2b_count: received %0d words expected 5", rx_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (rx_log[i] !== 8'(i + 1)) begin
                    n_fail++;
                    $display("FAIL b2b_order: word %0d=%02h expected %02h", i, rx_log[i], 8'(i + 1));
                end
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: busy=%b expected 0", busy); end
    endtask

    task automatic test_overflow();
        apply_reset();
        rx_log.delete();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0);
        n_checks++;
        if (ev_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_fill: ev_ready=%b expected 0", ev_ready); end
        cycle(1'b1, 8'hFF, 1'b0);
        n_checks += 2;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: overflow=%b expected 1", overflow); end
        if (ev_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_unchanged: ev_ready=%b expected 0", ev_ready); end
        cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: overflow=%b expected 0", overflow); end
        cycle(1'b1, 8'hFF, 1'b1);
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: overflow=%b expected 1", overflow); end
        cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: overflow=%b expected 1", overflow); end
        repeat (5) cpu_handshake(1);
        repeat (8) cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (rx_log.size() != 5) begin n_fail++; $display("FAIL ovf_count: received %0d words expected 5", rx_log.size()); end
        foreach (rx_log[i]) begin
            n_checks++;
            if (rx_log[i] === 8'hFF) begin n_fail++; $display("FAIL ovf_dropped_sent: word %0d=ff was transmitted", i); end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_init: timeout_err=%b expected 0", timeout_err); end
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (req_out !== 1'b1) begin n_fail++; $display("FAIL tmo_req: req_out=%b expected 1", req_out); end
        repeat (TIMEOUT_CYC - 1) cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: timeout_err=%b expected 0 after %0d cycles", timeout_err, TIMEOUT_CYC - 1); end
        cycle(1'b0, '0, 1'b0);
        n_checks += 2;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_exact: timeout_err=%b expected 1 after %0d cycles", timeout_err, TIMEOUT_CYC); end
        if (req_out !== 1'b1)     begin n_fail++; $display("FAIL tmo_no_abort: req_out=%b expected 1", req_out); end
        repeat (3) cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (req_out !== 1'b1) begin n_fail++; $display("FAIL tmo_hold: req_out=%b expected 1", req_out); end
        cpu_handshake(0);
        repeat (4) cycle(1'b0, '0, 1'b0);
        n_checks += 2;
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL tmo_complete: busy=%b expected 0", busy); end
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: timeout_err=%b expected 1", timeout_err); end
        cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: timeout_err=%b expected 0", timeout_err); end
    endtask

    task automatic test_reset_mid();
        int n_rx;
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0);
        n_checks++;
        if (req_out !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: req_out=%b expected 1", req_out); end
        apply_reset();
        n_checks += 4;
        if (req_out !== 1'b0)   begin n_fail++; $display("FAIL midrst_req: req_out=%b expected 0", req_out); end
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data: data_out=%02h expected 00", data_out); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: busy=%b expected 0", busy); end
        if (ev_ready !== 1'b1)  begin n_fail++; $display("FAIL midrst_ready: ev_ready=%b expected 1", ev_ready); end
        n_rx = rx_log.size();
        repeat (20) cycle(1'b0, '0, 1'b0);
        n_checks += 2;
        if (rx_log.size() != n_rx) begin n_fail++; $display("FAIL midrst_flushed: %0d words sent after reset expected 0", rx_log.size() - n_rx); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL midrst_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_simul_pop();
        apply_reset();
        rx_log.delete();
        cycle(1'b1, 8'h41, 1'b0);
        cycle(1'b1, 8'h42, 1'b0);
        ack_in = 1'b1;
        repeat (SYNC_STAGES + 1) cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (req_out !== 1'b0) begin n_fail++; $display("FAIL sim_ack: req_out=%b expected 0", req_out); end
        ack_in = 1'b0;
        repeat (SYNC_STAGES + 1) cycle(1'b0, '0, 1'b0);
        // FSM is IDLE with one word queued: push and pop on the same edge.
        cycle(1'b1, 8'h43, 1'b0);
        n_checks += 2;
        if (req_out !== 1'b1)   begin n_fail++; $display("FAIL sim_launch: req_out=%b expected 1", req_out); end
        if (data_out !== 8'h42) begin n_fail++; $display("FAIL sim_data: data_out=%02h expected 42", data_out); end
        cycle(1'b1, 8'h44, 1'b0);
        cycle(1'b1, 8'h45, 1'b0);
        n_checks++;
        if (ev_ready !== 1'b1) begin n_fail++; $display("FAIL sim_occ3: ev_ready=%b expected 1", ev_ready); end
        cycle(1'b1, 8'h46, 1'b0);
        n_checks += 2;
        if (ev_ready !== 1'b0) begin n_fail++; $display("FAIL sim_occ4: ev_ready=%b expected 0", ev_ready); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL sim_nodrop: overflow=%b expected 0", overflow); end
        repeat (5) cpu_handshake(1);
        repeat (4) cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (rx_log.size() != 6) begin
            n_fail++;
            $display("FAIL sim_count: received %0d words expected 6", rx_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (rx_log[i] !== 8'h41 + 8'(i)) begin
                    n_fail++;
                    $display("FAIL sim_order: word %0d=%02h expected %02h", i, rx_log[i], 8'h41 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_random();
        int  cpu_ph;
        int  cpu_wait;
        int  n;
        logic v;
        logic clr;
        logic [DATA_W-1:0] d;
        apply_reset();
        cpu_ph   = 0;
        cpu_wait = 0;
        for (int c = 0; c < 600; c++) begin
            if (cpu_ph == 0 && req_out === 1'b1) begin
                if (cpu_wait == 0) begin ack_in = 1'b1; cpu_ph = 1; cpu_wait = $urandom_range(0, 4); end
                else cpu_wait--;
            end else if (cpu_ph == 1 && req_out === 1'b0) begin
                if (cpu_wait == 0) begin ack_in = 1'b0; cpu_ph = 0; cpu_wait = $urandom_range(0, 4); end
                else cpu_wait--;
            end
            v   = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 31) == 0);
            d   = DATA_W'($urandom);
            cycle(v, d, clr);
            n_checks++;
            if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rnd_tmo: timeout_err=%b expected 0", timeout_err); end
        end
        n = 0;
        while ((pend_q.size() != 0 || busy !== 1'b0 || ack_in !== 1'b0) && n < 400) begin
            if (cpu_ph == 0 && req_out === 1'b1) begin ack_in = 1'b1; cpu_ph = 1; end
            else if (cpu_ph == 1 && req_out === 1'b0) begin ack_in = 1'b0; cpu_ph = 0; end
            cycle(1'b0, '0, 1'b0);
            n++;
        end
        n_checks += 2;
        if (pend_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: %0d words never sent", pend_q.size()); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL rnd_busy: busy=%b expected 0", busy); end
    endtask

    initial begin
        rst      = 1'b1;
        ev_valid = 1'b0;
        ev_data  = '0;
        ack_in   = 1'b0;
        clr_err  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_simul_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
